slc3_mem_responder: RTL and testbench

Memory-side responder for the SLC-3 CPU bus: answers the CPU's MAR-driven address with OE/WE strobes, backing a word-addressed on-chip RAM plus one memory-mapped I/O location (switches in, hex display out). It sits between the CPU datapath's MAR/MDR and the board I/O, replacing the external SRAM path. After reset it clears its RAM with an internal sequencer and signals readiness before serving any access.

---
 rtl/slc3_mem_pkg.sv | 28 ++
 rtl/slc3_ram_sp.sv | 35 +++
 rtl/slc3_mem_responder.sv | 137 +++++++++++++
 tb/tb_slc3_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slc3_mem_pkg
// Description : Shared types and constants for the SLC-3 memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package slc3_mem_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    SERVE = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_SW   = 2'd2
  } rd_src_t;

  localparam logic [15:0] MMIO_SW_HEX_ADDR = 16'hFFFF;

  // Shift-based test stays legal when depth_log2 = 16 (whole space in range).
  function automatic logic in_range(input logic [15:0] addr, input int depth_log2);
    in_range = ((addr >> depth_log2) == 16'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : slc3_ram_sp
// Description : Single-port synchronous RAM, registered read with read enable.
// Revision    : 1.0 - initial release
// ============================================================================
module slc3_ram_sp #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Read data only moves on a read so the top can hold it between reads.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/slc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : slc3_mem_responder
// Description : SLC-3 bus responder: clears RAM after reset, then serves
//               RAM reads/writes plus one switch/hex MMIO word.
// Revision    : 1.0 - initial release
// ============================================================================
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] MMIO_ADDR  = MMIO_SW_HEX_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_from_CPU,
  input  logic [9:0]  SW,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] HEX_Data,
  output logic        Ready
);

  localparam logic [DEPTH_LOG2-1:0] c_CLR_LAST = '1;
  localparam logic [DEPTH_LOG2-1:0] c_CLR_STEP = DEPTH_LOG2'(1);

  mem_state_t            r_state,    w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_clr_addr, w_clr_addr_nxt;
  rd_src_t               r_rd_src,   w_rd_src_nxt;
  logic [15:0]           r_sw_data,  w_sw_data_nxt;
  logic [15:0]           r_hex,      w_hex_nxt;

  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [15:0]           w_ram_wdata;
  logic [15:0]           w_ram_rdata;
  logic                  w_is_mmio;
  logic                  w_in_range;

  assign w_is_mmio  = (ADDR == MMIO_ADDR);
  assign w_in_range = in_range(ADDR, DEPTH_LOG2);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= INIT;
      r_clr_addr <= '0;
      r_rd_src   <= SRC_ZERO;
      r_sw_data  <= 16'h0000;
      r_hex      <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_rd_src   <= w_rd_src_nxt;
      r_sw_data  <= w_sw_data_nxt;
      r_hex      <= w_hex_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_rd_src_nxt   = r_rd_src;
    w_sw_data_nxt  = r_sw_data;
    w_hex_nxt      = r_hex;
    w_ram_we       = 1'b0;
    w_ram_re       = 1'b0;
    w_ram_addr     = ADDR[DEPTH_LOG2-1:0];
    w_ram_wdata    = Data_from_CPU;

    case (r_state)
      INIT: begin
        w_ram_we     = 1'b1;
        w_ram_addr   = r_clr_addr;
        w_ram_wdata  = 16'h0000;
        w_rd_src_nxt = SRC_ZERO;
        if (r_clr_addr == c_CLR_LAST) begin
          w_state_nxt = SERVE;
        end else begin
          w_clr_addr_nxt = r_clr_addr + c_CLR_STEP;
        end
      end
      SERVE: begin
        // MMIO is decoded first so it wins even when the RAM spans all 64K.
        if (WE) begin
          if (w_is_mmio) begin
            w_hex_nxt = Data_from_CPU;
          end else if (w_in_range) begin
            w_ram_we = 1'b1;
          end
        end else if (OE) begin
          if (w_is_mmio) begin
            w_rd_src_nxt  = SRC_SW;
            w_sw_data_nxt = {6'b0, SW};
          end else if (w_in_range) begin
            w_ram_re     = 1'b1;
            w_rd_src_nxt = SRC_RAM;
          end else begin
            w_rd_src_nxt = SRC_ZERO;
          end
        end
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  slc3_ram_sp #(
    .AW (DEPTH_LOG2),
    .DW (16)
  ) u_ram (
    .clk     (Clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // The select is registered alongside the RAM read, keeping all sources aligned.
  always_comb begin
    Data_to_CPU = 16'h0000;
    case (r_rd_src)
      SRC_RAM: Data_to_CPU = w_ram_rdata;
      SRC_SW:  Data_to_CPU = r_sw_data;
      default: Data_to_CPU = 16'h0000;
    endcase
  end

  assign HEX_Data = r_hex;
  assign Ready    = (r_state == SERVE);

endmodule
`default_nettype wire

// File: tb/tb_slc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_slc3_mem_responder
// Description : Self-checking bench for slc3_mem_responder against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_from_CPU;
  logic [9:0]  SW;
  logic [15:0] Data_to_CPU;
  logic [15:0] HEX_Data;
  logic        Ready;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_mem [0:1023];
  logic [15:0] m_hex;
  logic [15:0] m_dout;
  bit          m_ready;
  int          m_init_edges;

  always #5 Clk = ~Clk;

  slc3_mem_responder dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ADDR          (ADDR),
    .OE            (OE),
    .WE            (WE),
    .Data_from_CPU (Data_from_CPU),
    .SW            (SW),
    .Data_to_CPU   (Data_to_CPU),
    .HEX_Data      (HEX_Data),
    .Ready         (Ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready      = 1'b0;
    m_init_edges = 0;
    m_hex        = 16'h0000;
    m_dout       = 16'h0000;
    for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0000;
  endtask

  // Apply the current inputs to the model, then advance one edge.
  task automatic cycle();
    logic [15:0] a;
    a = ADDR;
    if (m_ready) begin
      if (WE) begin
        if (a == 16'hFFFF)     m_hex = Data_from_CPU;
        else if (a < 16'd1024) m_mem[a[9:0]] = Data_from_CPU;
      end else if (OE) begin
        if (a == 16'hFFFF)     m_dout = {6'b0, SW};
        else if (a < 16'd1024) m_dout = m_mem[a[9:0]];
        else                   m_dout = 16'h0000;
      end
    end else begin
      m_init_edges++;
      if (m_init_edges == 1024) m_ready = 1'b1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_dout"},  Data_to_CPU, m_dout);
    chk({tag, "_hex"},   HEX_Data, m_hex);
    chk({tag, "_ready"}, {15'b0, Ready}, {15'b0, m_ready});
  endtask

  task automatic access(input string tag, input logic we, input logic oe,
                        input logic [15:0] addr, input logic [15:0] data);
    WE            = we;
    OE            = oe;
    ADDR          = addr;
    Data_from_CPU = data;
    cycle();
    check_outputs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #1;
    Reset = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    Reset = 1'b1;
  endtask

  initial begin
    Reset         = 1'b0;
    OE            = 1'b1;
    WE            = 1'b0;
    ADDR          = 16'd5;
    Data_from_CPU = 16'h0000;
    SW            = 10'h000;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_outputs("reset");
    Reset = 1'b1;

    // Clear sequence with OE held at address 5
    for (int i = 0; i < 1024; i++) begin
      cycle();
      check_outputs("init");
    end
    access("rd5_after_init", 1'b0, 1'b1, 16'd5, 16'h0000);

    access("wr_0010",   1'b1, 1'b0, 16'h0010, 16'hBEEF);
    access("rd_0010",   1'b0, 1'b1, 16'h0010, 16'h0000);
    access("wr_03FF",   1'b1, 1'b0, 16'h03FF, 16'h1234);
    access("rd_03FF",   1'b0, 1'b1, 16'h03FF, 16'h0000);
    access("idle_hold", 1'b0, 1'b0, 16'h0010, 16'h5555);

    SW = 10'h2A5;
    access("rd_sw",     1'b0, 1'b1, 16'hFFFF, 16'h0000);
    access("wr_hex",    1'b1, 1'b0, 16'hFFFF, 16'h7C3E);
    access("rd_03FF_2", 1'b0, 1'b1, 16'h03FF, 16'h0000);

    access("wr_oor",    1'b1, 1'b0, 16'h0400, 16'hAAAA);
    access("rd_oor",    1'b0, 1'b1, 16'h0400, 16'h0000);
    access("rd_0000",   1'b0, 1'b1, 16'h0000, 16'h0000);

    access("wr_3",      1'b1, 1'b0, 16'h0003, 16'h1111);
    access("rd_3",      1'b0, 1'b1, 16'h0003, 16'h0000);
    access("oe_we_3",   1'b1, 1'b1, 16'h0003, 16'h2222);
    access("rd_3_new",  1'b0, 1'b1, 16'h0003, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = 16'($urandom_range(0, 1023));
      else if (sel == 6) a = 16'hFFFF;
      else if (sel == 7) a = 16'h0400;
      else if (sel == 8) a = 16'($urandom);
      else               a = 16'h03FF;
      SW = 10'($urandom);
      access("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
             a, 16'($urandom));
    end

    // Reset while serving, with HEX and read data both non-zero
    access("pre_wr_hex", 1'b1, 1'b0, 16'hFFFF, 16'h7C3E);
    access("pre_wr_20",  1'b1, 1'b0, 16'h0020, 16'h5A5A);
    access("pre_rd_20",  1'b0, 1'b1, 16'h0020, 16'h0000);
    reset_pulse("rst_serve");
    OE   = 1'b1;
    WE   = 1'b1;
    ADDR = 16'hFFFF;
    for (int i = 0; i < 1024; i++) begin
      cycle();
      check_outputs("reinit1");
    end

    // Reset in the middle of the clear sequence
    access("pre_wr_20b", 1'b1, 1'b0, 16'h0020, 16'h5A5A);
    reset_pulse("rst_pre");
    for (int i = 0; i < 500; i++) begin
      cycle();
      check_outputs("init_part");
    end
    reset_pulse("rst_mid_init");
    for (int i = 0; i < 1024; i++) begin
      cycle();
      check_outputs("reinit2");
    end
    access("rd_20_cleared", 1'b0, 1'b1, 16'h0020, 16'h0000);
    access("rd_sw_final",   1'b0, 1'b1, 16'hFFFF, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
